// File: rtl/ssp_pkg.sv
// ssp_pkg: shared opcode, register-file and instruction-field constants for the superscalar core
package ssp_pkg;
  localparam int DEF_RAW_AW = 5;
  localparam int DEF_NREGS = 32;
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_AND = 6'b000010;
  localparam logic [5:0] OP_OR = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_LW = 6'b000101;
  localparam logic [5:0] OP_SW = 6'b000110;
  localparam logic [5:0] OP_BEQ = 6'b000111;
  localparam logic [5:0] OP_J = 6'b001000;
  localparam logic [5:0] OP_JAL = 6'b001001;
  localparam logic [5:0] OP_NOP = 6'b111111;
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS1_HI = 25;
  localparam int RS1_LO = 21;
  localparam int RS2_HI = 20;
  localparam int RS2_LO = 16;
  localparam int RDR_HI = 15;
  localparam int RDR_LO = 11;
endpackage

// File: rtl/raw_issue_scoreboard_if.sv
// raw_issue_scoreboard_if: decode-to-scoreboard issue bundle and grant/busy feedback
interface raw_issue_scoreboard_if #(
  parameter int ISSUE_W = 2,
  parameter int RAW_AW = 5,
  parameter int NREGS = 32
);
  logic [ISSUE_W-1:0] slot_valid;
  logic [ISSUE_W*RAW_AW-1:0] slot_rs1;
  logic [ISSUE_W*RAW_AW-1:0] slot_rs2;
  logic [ISSUE_W-1:0] slot_use_rs2;
  logic [ISSUE_W*RAW_AW-1:0] slot_rd;
  logic [ISSUE_W-1:0] slot_wr;
  logic [ISSUE_W-1:0] issue_grant;
  logic stall;
  logic [NREGS-1:0] busy_vec;
  modport master (
    output slot_valid, slot_rs1, slot_rs2, slot_use_rs2, slot_rd, slot_wr,
    input issue_grant, stall, busy_vec
  );
  modport slave (
    input slot_valid, slot_rs1, slot_rs2, slot_use_rs2, slot_rd, slot_wr,
    output issue_grant, stall, busy_vec
  );
endinterface

// File: rtl/sb_reg_counter.sv
// sb_reg_counter: per-register write-back latency countdown with readiness output
module sb_reg_counter #(
  parameter int LAT = 3,
  parameter int FWD_EN = 0,
  parameter int FWD_READY = 2,
  localparam int CW = $clog2(LAT + 1)
) (
  input logic clk1,
  input logic reset,
  input logic clr,
  input logic load,
  output logic ready
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : load ? CW'(LAT) : cnt_q - CW'(cnt_q != '0);
  always_ff @(posedge clk1) cnt_q <= reset ? '0 : cnt_d;
  assign ready = (FWD_EN != 0) ? (cnt_q <= CW'(FWD_READY)) : (cnt_q == '0);
endmodule

// File: rtl/raw_issue_scoreboard.sv
// raw_issue_scoreboard: in-order issue grant with intra-bundle and in-flight RAW hazard checks
module raw_issue_scoreboard
  import ssp_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int NREGS = DEF_NREGS,
  parameter int RAW_AW = DEF_RAW_AW,
  parameter int LAT = 3,
  parameter int FWD_EN = 0,
  parameter int FWD_READY = 2
) (
  input logic clk1,
  input logic reset,
  input logic flush,
  raw_issue_scoreboard_if.slave sb
);
  logic [NREGS-1:0] rdy;
  logic [NREGS-1:1] load;
  logic [ISSUE_W-1:0] grant;
  logic ok;
  logic [RAW_AW-1:0] rs1, rs2, rdj, rdk;
  assign rdy[0] = 1'b1;
  genvar r;
  for (r = 1; r < NREGS; r++) begin : g_cnt
    sb_reg_counter #(.LAT(LAT), .FWD_EN(FWD_EN), .FWD_READY(FWD_READY)) u_cnt (
      .clk1(clk1),
      .reset(reset),
      .clr(flush),
      .load(load[r]),
      .ready(rdy[r])
    );
  end
  always_comb begin
    grant = '0;
    ok = 1'b1;
    rs1 = '0;
    rs2 = '0;
    rdj = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      rs1 = sb.slot_rs1[k*RAW_AW +: RAW_AW];
      rs2 = sb.slot_rs2[k*RAW_AW +: RAW_AW];
      ok = ok & sb.slot_valid[k] & rdy[rs1] & (rdy[rs2] | ~sb.slot_use_rs2[k]);
      for (int j = 0; j < k; j++) begin
        rdj = sb.slot_rd[j*RAW_AW +: RAW_AW];
        if (sb.slot_wr[j] && rdj != '0 && (rdj == rs1 || (sb.slot_use_rs2[k] && rdj == rs2))) ok = 1'b0;
      end
      grant[k] = ok & ~(reset | flush);
    end
  end
  always_comb begin
    load = '0;
    rdk = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      rdk = sb.slot_rd[k*RAW_AW +: RAW_AW];
      if (grant[k] && sb.slot_wr[k] && rdk != '0) load[rdk] = 1'b1;
    end
  end
  assign sb.issue_grant = grant;
  assign sb.stall = ~(reset | flush) & |(sb.slot_valid & ~grant);
  assign sb.busy_vec = reset ? '0 : ~rdy;
endmodule

// File: tb/tb_raw_issue_scoreboard.sv
// tb_raw_issue_scoreboard: directed scoreboard bench for non-forwarding and forwarding scoreboards
module tb_raw_issue_scoreboard;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;
  typedef struct {
    string tag;
    bit d;
    logic [1:0] g;
    logic s;
    logic [31:0] m;
    logic [31:0] b;
  } exp_t;
  exp_t q[$];
  int n_assert = 0;
  int n_fail = 0;
  logic clk1 = 1'b0;
  logic reset, flush;
  logic [1:0] valid, wr_v, use_v;
  logic [9:0] rs1, rs2, rd;
  always #5 clk1 = ~clk1;
  raw_issue_scoreboard_if #(.ISSUE_W(2), .RAW_AW(5), .NREGS(32)) if0 ();
  raw_issue_scoreboard_if #(.ISSUE_W(2), .RAW_AW(5), .NREGS(32)) if1 ();
  assign if0.slot_valid = valid;
  assign if0.slot_rs1 = rs1;
  assign if0.slot_rs2 = rs2;
  assign if0.slot_use_rs2 = use_v;
  assign if0.slot_rd = rd;
  assign if0.slot_wr = wr_v;
  assign if1.slot_valid = valid;
  assign if1.slot_rs1 = rs1;
  assign if1.slot_rs2 = rs2;
  assign if1.slot_use_rs2 = use_v;
  assign if1.slot_rd = rd;
  assign if1.slot_wr = wr_v;
  raw_issue_scoreboard #(.ISSUE_W(2), .NREGS(32), .RAW_AW(5), .LAT(3), .FWD_EN(0), .FWD_READY(2)) dut0 (
    .clk1(clk1), .reset(reset), .flush(flush), .sb(if0)
  );
  raw_issue_scoreboard #(.ISSUE_W(2), .NREGS(32), .RAW_AW(5), .LAT(3), .FWD_EN(1), .FWD_READY(2)) dut1 (
    .clk1(clk1), .reset(reset), .flush(flush), .sb(if1)
  );
  function automatic logic [31:0] bit_of(input int n);
    return 32'h1 << n;
  endfunction
  task automatic drv(input logic [1:0] v, input logic [1:0] w, input logic [1:0] u,
                     input logic [4:0] a0, input logic [4:0] b0, input logic [4:0] d0,
                     input logic [4:0] a1, input logic [4:0] b1, input logic [4:0] d1);
    valid = v;
    wr_v = w;
    use_v = u;
    rs1 = {a1, a0};
    rs2 = {b1, b0};
    rd = {d1, d0};
  endtask
  task automatic expect_out(input string tag, input bit d, input logic [1:0] g, input logic s,
                            input logic [31:0] m, input logic [31:0] b);
    exp_t e;
    e.tag = tag;
    e.d = d;
    e.g = g;
    e.s = s;
    e.m = m;
    e.b = b;
    q.push_back(e);
  endtask
  task automatic tick();
    exp_t e;
    logic [1:0] og;
    logic os;
    logic [31:0] ob;
    @(negedge clk1);
    while (q.size() > 0) begin
      e = q.pop_front();
      og = e.d ? if1.issue_grant : if0.issue_grant;
      os = e.d ? if1.stall : if0.stall;
      ob = (e.d ? if1.busy_vec : if0.busy_vec) & e.m;
      n_assert++;
      assert ({og, os, ob} === {e.g, e.s, e.b}) else begin
        n_fail++;
        $error("FAIL %s dut%0d: grant=%b stall=%b busy=%h, expected grant=%b stall=%b busy=%h",
               e.tag, e.d, og, os, ob, e.g, e.s, e.b);
      end
    end
    @(posedge clk1);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    flush = 1'b0;
    drv(2'b11, 2'b11, 2'b11, 5'd1, 5'd2, 5'd5, 5'd3, 5'd4, 5'd6);
    for (int i = 0; i < 3; i++) begin
      expect_out("reset", 0, 2'b00, 1'b0, ALL, 32'h0);
      if (i == 2) expect_out("reset_fwd", 1, 2'b00, 1'b0, ALL, 32'h0);
      tick();
    end
    reset = 1'b0;
    drv(2'b11, 2'b11, 2'b11, 5'd1, 5'd2, 5'd14, 5'd1, 5'd3, 5'd15);
    expect_out("indep_pair", 0, 2'b11, 1'b0, ALL, 32'h0);
    tick();
    drv(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_out("busy_set", 0, 2'b00, 1'b0, bit_of(14) | bit_of(15), bit_of(14) | bit_of(15));
    tick();
    expect_out("busy_hold", 0, 2'b00, 1'b0, bit_of(14), bit_of(14));
    tick();
    expect_out("busy_hold", 0, 2'b00, 1'b0, bit_of(14), bit_of(14));
    tick();
    expect_out("busy_clear", 0, 2'b00, 1'b0, ALL, 32'h0);
    tick();
    drv(2'b11, 2'b11, 2'b11, 5'd1, 5'd2, 5'd14, 5'd1, 5'd14, 5'd16);
    expect_out("intra_raw", 0, 2'b01, 1'b1, ALL, 32'h0);
    tick();
    drv(2'b01, 2'b01, 2'b01, 5'd1, 5'd14, 5'd16, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      expect_out("raw_wait", 0, 2'b00, 1'b1, bit_of(14), bit_of(14));
      tick();
    end
    expect_out("raw_go", 0, 2'b01, 1'b0, bit_of(14), 32'h0);
    tick();
    drv(2'b01, 2'b01, 2'b00, 5'd1, 5'd0, 5'd17, 5'd0, 5'd0, 5'd0);
    expect_out("fwd_wr", 1, 2'b01, 1'b0, bit_of(17), 32'h0);
    expect_out("nofwd_wr", 0, 2'b01, 1'b0, bit_of(17), 32'h0);
    tick();
    drv(2'b01, 2'b00, 2'b00, 5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_out("fwd_busy", 1, 2'b00, 1'b1, bit_of(17), bit_of(17));
    expect_out("nofwd_busy", 0, 2'b00, 1'b1, bit_of(17), bit_of(17));
    tick();
    expect_out("fwd_go", 1, 2'b01, 1'b0, bit_of(17), 32'h0);
    expect_out("nofwd_wait", 0, 2'b00, 1'b1, bit_of(17), bit_of(17));
    tick();
    expect_out("nofwd_wait", 0, 2'b00, 1'b1, bit_of(17), bit_of(17));
    tick();
    expect_out("nofwd_go", 0, 2'b01, 1'b0, bit_of(17), 32'h0);
    tick();
    drv(2'b11, 2'b11, 2'b00, 5'd1, 5'd2, 5'd0, 5'd3, 5'd4, 5'd0);
    expect_out("r0_write", 0, 2'b11, 1'b0, ALL, 32'h0);
    tick();
    drv(2'b11, 2'b00, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_out("r0_read", 0, 2'b11, 1'b0, ALL, 32'h0);
    tick();
    drv(2'b11, 2'b11, 2'b00, 5'd1, 5'd2, 5'd18, 5'd3, 5'd4, 5'd18);
    expect_out("waw_pair", 0, 2'b11, 1'b0, ALL, 32'h0);
    tick();
    drv(2'b11, 2'b01, 2'b00, 5'd1, 5'd2, 5'd18, 5'd18, 5'd0, 5'd0);
    expect_out("waw_rewrite", 0, 2'b01, 1'b1, bit_of(18), bit_of(18));
    tick();
    drv(2'b01, 2'b00, 2'b00, 5'd18, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      expect_out("waw_wait", 0, 2'b00, 1'b1, bit_of(18), bit_of(18));
      tick();
    end
    expect_out("waw_go", 0, 2'b01, 1'b0, bit_of(18), 32'h0);
    tick();
    drv(2'b01, 2'b01, 2'b00, 5'd1, 5'd2, 5'd19, 5'd0, 5'd0, 5'd0);
    expect_out("flush_wr", 0, 2'b01, 1'b0, bit_of(19), 32'h0);
    tick();
    drv(2'b00, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    expect_out("flush_cnt", 0, 2'b00, 1'b0, bit_of(19), bit_of(19));
    tick();
    drv(2'b01, 2'b00, 2'b00, 5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    flush = 1'b1;
    expect_out("flush_cycle", 0, 2'b00, 1'b0, bit_of(19), bit_of(19));
    tick();
    flush = 1'b0;
    expect_out("flush_after", 0, 2'b01, 1'b0, ALL, 32'h0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
